bus_memory_responder: RTL and testbench

- Memory-side responder for the CPU's 16-bit byte-addressed data bus; the counterpart of the CPU-side bus controller that splits unaligned word accesses into two phases.
- Holds a word-organised RAM with two byte lanes, performs lane-masked writes and aligns or sign-extends read data.
- Handles each access through a req/ack handshake with a programmable wait-state count.
- Sits between the CPU bus controller and the system RAM.

---
 rtl/bus_memory_responder_if.sv | 25 ++
 rtl/bus_memory_responder.sv | 160 ++++++++++++++++
 tb/tb_bus_memory_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_memory_responder_if.sv
// Data-bus handshake between the CPU bus controller (master) and the memory responder (slave).
interface bus_memory_responder_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic                  word;
  logic                  sign_extend;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           wdata;
  logic [15:0]           rdata;
  logic                  ack;
  logic                  err;
  logic                  busy;

  modport master (
    output req, we, word, sign_extend, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, word, sign_extend, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/bus_memory_responder.sv
// Word-organised RAM behind a req/ack data bus: lane-masked writes, aligned or
// sign-extended reads, programmable wait states and out-of-range error reporting.
module bus_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_memory_responder_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  word_q, word_d;
  logic                  sext_q, sext_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic [15:0]           mem [DEPTH_WORDS];

  // Access fields: straight from the bus on the accept edge, latched copies afterwards
  logic                  acc_we, acc_word, acc_sext, acc_odd;
  logic [ADDR_WIDTH-1:0] acc_addr, acc_wi;
  logic [15:0]           acc_wdata;
  logic [IDX_W-1:0]      acc_idx;
  logic                  range_err;
  logic [15:0]           mem_word;
  logic [7:0]            lane_b;
  logic [15:0]           read_val;
  logic                  enter_resp;
  logic                  wr_hi, wr_lo;
  logic [7:0]            wr_hi_data;

  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = bus.we;
      acc_word  = bus.word;
      acc_sext  = bus.sign_extend;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
    end else begin
      acc_we    = we_q;
      acc_word  = word_q;
      acc_sext  = sext_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_odd    = acc_addr[0];
    acc_wi     = acc_addr >> 1;
    range_err  = (acc_wi >= ADDR_WIDTH'(DEPTH_WORDS));
    acc_idx    = acc_wi[IDX_W-1:0];
    mem_word   = mem[acc_idx];
    lane_b     = acc_odd ? mem_word[15:8] : mem_word[7:0];
    if (acc_word) begin
      read_val = acc_odd ? {mem_word[7:0], mem_word[15:8]} : mem_word;
    end else begin
      read_val = acc_sext ? {{8{lane_b[7]}}, lane_b} : {8'h00, lane_b};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    word_d     = word_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          word_d  = bus.word;
          sext_d  = bus.sign_extend;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) enter_resp = 1'b1;
          else                  state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        if (!bus.req)                 state_d    = ST_IDLE;
        else if (cnt_q <= CNT_W'(1))  enter_resp = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The access itself happens on the edge into RESP so ack/rdata are visible during RESP
    if (enter_resp) begin
      state_d = ST_RESP;
      ack_d   = 1'b1;
      err_d   = range_err;
      if (range_err)    rdata_d = 16'h0000;
      else if (!acc_we) rdata_d = read_val;
    end
  end

  assign wr_lo      = enter_resp && acc_we && !range_err && !acc_odd;
  assign wr_hi      = enter_resp && acc_we && !range_err && (acc_odd || acc_word);
  assign wr_hi_data = acc_odd ? acc_wdata[7:0] : acc_wdata[15:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      word_q  <= word_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // RAM is never cleared; reset only suppresses a pending write
  always_ff @(posedge clk) begin
    if (!reset && wr_lo) mem[acc_idx][7:0]  <= acc_wdata[7:0];
    if (!reset && wr_hi) mem[acc_idx][15:8] <= wr_hi_data;
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bus_memory_responder.sv
// Self-checking bench: two responders (1 and 3 wait states) against a transaction-level memory model.
module tb_bus_memory_responder;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WS0   = 1;
  localparam int unsigned WS1   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int            sel;
  logic          req, we, word, sx;
  logic [AW-1:0] addr;
  logic [15:0]   wdata;

  bus_memory_responder_if #(.ADDR_WIDTH(AW)) bus0 ();
  bus_memory_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

  assign bus0.req = req && (sel == 0);
  assign bus1.req = req && (sel == 1);
  assign bus0.we = we;   assign bus1.we = we;
  assign bus0.word = word; assign bus1.word = word;
  assign bus0.sign_extend = sx; assign bus1.sign_extend = sx;
  assign bus0.addr = addr;  assign bus1.addr = addr;
  assign bus0.wdata = wdata; assign bus1.wdata = wdata;

  bus_memory_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  bus_memory_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  logic [15:0] o_rdata [2];
  logic        o_ack [2], o_err [2], o_busy [2];
  assign o_rdata[0] = bus0.rdata; assign o_rdata[1] = bus1.rdata;
  assign o_ack[0]   = bus0.ack;   assign o_ack[1]   = bus1.ack;
  assign o_err[0]   = bus0.err;   assign o_err[1]   = bus1.err;
  assign o_busy[0]  = bus0.busy;  assign o_busy[1]  = bus1.busy;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: accept cycle + wait count gives the access cycle
  int          ws_of [2] = '{int'(WS0), int'(WS1)};
  int          cyc = 0;
  bit          seen_reset = 1'b0;
  bit          pend [2], in_resp [2];
  int          acc_cyc [2];
  logic        m_we [2], m_word [2], m_sx [2];
  logic [AW-1:0] m_addr [2];
  logic [15:0] m_wdata [2];
  logic        e_ack [2], e_err [2];
  logic [15:0] e_rdata [2];
  logic [15:0] mm [2][DEPTH];

  task automatic model_access(input int d);
    int          wi;
    logic [15:0] m;
    logic [7:0]  b;
    bit          odd;
    wi  = int'(m_addr[d] >> 1);
    odd = m_addr[d][0];
    e_ack[d]   = 1'b1;
    in_resp[d] = 1'b1;
    if (wi >= int'(DEPTH)) begin
      e_err[d]   = 1'b1;
      e_rdata[d] = 16'h0000;
      return;
    end
    m = mm[d][wi];
    if (m_we[d]) begin
      if (m_word[d] && !odd)      m = m_wdata[d];
      else if (m_word[d] && odd)  m = {m_wdata[d][7:0], m[7:0]};
      else if (!odd)              m = {m[15:8], m_wdata[d][7:0]};
      else                        m = {m_wdata[d][7:0], m[7:0]};
      mm[d][wi] = m;
    end else if (m_word[d]) begin
      e_rdata[d] = odd ? {m[7:0], m[15:8]} : m;
    end else begin
      b = odd ? m[15:8] : m[7:0];
      e_rdata[d] = m_sx[d] ? {{8{b[7]}}, b} : {8'h00, b};
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit r;
      r = req && (sel == d);
      if (reset) begin
        pend[d] = 1'b0; in_resp[d] = 1'b0;
        e_ack[d] = 1'b0; e_err[d] = 1'b0; e_rdata[d] = 16'h0000;
      end else begin
        e_ack[d] = 1'b0;
        e_err[d] = 1'b0;
        if (in_resp[d]) begin
          in_resp[d] = 1'b0;
          pend[d]    = 1'b0;
        end else if (pend[d]) begin
          if (!r) pend[d] = 1'b0;
          else if (cyc == acc_cyc[d] + ws_of[d]) model_access(d);
        end else if (r) begin
          pend[d] = 1'b1; acc_cyc[d] = cyc;
          m_we[d] = we; m_word[d] = word; m_sx[d] = sx; m_addr[d] = addr; m_wdata[d] = wdata;
          if (ws_of[d] == 0) model_access(d);
        end
      end
    end
    if (reset) seen_reset = 1'b1;
    cyc++;
  end

  // Cycle-by-cycle comparison of both responders against the model
  always @(negedge clk) begin
    if (seen_reset) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cyc_ack%0d", d),   16'(o_ack[d]),  16'(e_ack[d]));
        chk($sformatf("cyc_err%0d", d),   16'(o_err[d]),  16'(e_err[d]));
        chk($sformatf("cyc_busy%0d", d),  16'(o_busy[d]), 16'(pend[d] || in_resp[d]));
        chk($sformatf("cyc_rdata%0d", d), o_rdata[d],     e_rdata[d]);
      end
    end
  end

  logic [15:0] got;
  bit          got_err;
  int          lat;
  logic [15:0] pre1 [DEPTH];

  task automatic access(input int d, input bit w, input bit wd, input bit s,
                        input logic [AW-1:0] a, input logic [15:0] wv);
    @(posedge clk); #1;
    sel = d; we = w; word = wd; sx = s; addr = a; wdata = wv; req = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (o_ack[d] === 1'b1) break;
    end
    chk("handshake_ack", 16'(o_ack[d]), 16'd1);
    got     = o_rdata[d];
    got_err = o_err[d];
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; sel = 0; we = 1'b0; word = 1'b0; sx = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", 16'(o_ack[0]), 16'd0);
    chk("reset_busy", 16'(o_busy[0]), 16'd0);
    chk("reset_rdata", o_rdata[0], 16'h0000);
    chk("reset_err", 16'(o_err[1]), 16'd0);
    reset = 1'b0;

    // Preload every word of both memories so the model knows all contents
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        logic [15:0] v;
        v = 16'($urandom);
        if (d == 1) pre1[i] = v;
        access(d, 1'b1, 1'b1, 1'b0, AW'(2 * i), v);
      end
    end

    // Aligned word write/read with one wait state
    access(0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    chk("wr_latency", 16'(lat), 16'd2);
    chk("wr_err", 16'(got_err), 16'd0);
    access(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd_latency", 16'(lat), 16'd2);
    chk("rd_word", got, 16'h1234);
    chk("model_rd_word", e_rdata[0], 16'h1234);

    // Byte lane write and sign/zero-extended reads
    access(0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h00AB);
    access(0, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000);
    chk("rd_byte_sx", got, 16'hFFAB);
    access(0, 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000);
    chk("rd_byte_zx", got, 16'h00AB);
    access(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd_word_merged", got, 16'hAB34);
    chk("model_word_merged", e_rdata[0], 16'hAB34);

    // Unaligned word write split into two phases
    access(0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h5555);
    access(0, 1'b1, 1'b1, 1'b0, 16'h0022, 16'h5555);
    access(0, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h00EF);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0022, 16'h00BE);
    access(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("unal_w10", got, 16'hEF55);
    access(0, 1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
    chk("unal_w11", got, 16'h55BE);
    access(0, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000);
    chk("rd_odd_word", got, 16'h55EF);
    chk("model_odd_word", e_rdata[0], 16'h55EF);

    // Out-of-range accesses
    access(0, 1'b0, 1'b1, 1'b0, AW'(2 * DEPTH), 16'h0000);
    chk("oor_err", 16'(got_err), 16'd1);
    chk("oor_rdata", got, 16'h0000);
    access(0, 1'b1, 1'b1, 1'b0, AW'(2 * DEPTH), 16'hDEAD);
    chk("oor_wr_err", 16'(got_err), 16'd1);
    access(0, 1'b1, 1'b0, 1'b0, 16'hF001, 16'h00C3);
    chk("oor_high_err", 16'(got_err), 16'd1);
    for (int i = 0; i < int'(DEPTH); i++) access(0, 1'b0, 1'b1, 1'b0, AW'(2 * i), 16'h0000);

    // Abort: req dropped in the first WAIT cycle of a write (3 wait states)
    @(posedge clk); #1;
    sel = 1; we = 1'b1; word = 1'b1; sx = 1'b0; addr = 16'h0030; wdata = 16'hDEAD; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("abort_busy_wait", 16'(o_busy[1]), 16'd1);
    @(posedge clk); @(negedge clk);
    chk("abort_busy_drop", 16'(o_busy[1]), 16'd0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ack", 16'(o_ack[1]), 16'd0);
    end
    access(1, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
    chk("abort_unchanged", got, pre1[24]);
    chk("wait3_latency", 16'(lat), 16'd4);

    // Reset during RESP of a read
    @(posedge clk); #1;
    sel = 0; we = 1'b0; word = 1'b1; sx = 1'b0; addr = 16'h0010; req = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("resp_ack_before_reset", 16'(o_ack[0]), 16'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("rst_resp_ack", 16'(o_ack[0]), 16'd0);
    chk("rst_resp_rdata", o_rdata[0], 16'h0000);
    chk("rst_resp_busy", 16'(o_busy[0]), 16'd0);
    reset = 1'b0;
    access(0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("ram_kept_after_reset", got, 16'hAB34);

    // Randomised traffic on both responders
    for (int n = 0; n < 250; n++) begin
      int          d;
      logic [AW-1:0] a;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = AW'($urandom);
      else                           a = AW'($urandom_range(0, 2 * DEPTH - 1));
      access(d, 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
